ppu_bbus_master: RTL

- Sequences single B-Bus register transactions (PAx address, PDx data, /PARD, /PAWR) into PPU1/PPU2 for the bringup top, replacing the constant idle tie-offs on the B-Bus pins.
- Owns the PA and PD level-shifter direction controls, including bus turnaround on PD.
- Upstream is a host command path using a valid/ready request interface with a read-response pulse.
- Downstream is the B-Bus pins.

---
 rtl/ppu_bbus_master.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ppu_bbus_master.sv
// -----------------------------------------------------------------------------
// ppu_bbus_master
//
// Sequences single B-Bus register transactions (PA address, PD data, /PARD,
// /PAWR) into PPU1/PPU2. A host issues one request at a time over a
// valid/ready handshake. Reads return their data as a one-cycle response pulse.
// The block also owns the PA/PD level-shifter direction controls and inserts a
// turnaround on PD whenever the data direction has to change.
//
// Transaction shape (each phase length is a parameter):
//   IDLE -> [TURN] -> SETUP -> STROBE -> HOLD -> IDLE
// TURN is present only when the PD direction has to flip.
//
// Optional feature:
//   `define PPU_BBUS_STATS_EN  -> stat_writes_o / stat_reads_o count completed
//                                 transactions (16-bit, wrapping).
//   undefined                  -> both ports read 0 and no counters exist.
//
// Ports:
//   clock_i        master clock (same clock that drives xin)
//   reset_i        synchronous, active-high reset
//   req_valid_i    request present
//   req_ready_o    request accepted when valid && ready
//   req_write_i    1 = write, 0 = read
//   req_addr_i     B-Bus register address ($21xx low byte)
//   req_data_i     write data
//   rsp_valid_o    one-cycle pulse carrying read data
//   rsp_data_o     read data, held until the next read completes
//   pa_o           PA bus
//   pd_out_o       PD drive value
//   pd_oe_o        FPGA PD output enable
//   pd_in_i        PD sampled value
//   pard_n_o       read strobe, active low
//   pawr_n_o       write strobe, active low
//   lvl_pa_dir_o   1 = FPGA drives PA
//   lvl_pd_dir_o   1 = FPGA drives PD
//   stat_writes_o  completed write count (optional)
//   stat_reads_o   completed read count (optional)
//
// All phase lengths must be at least 1 and at most 256 cycles (8-bit counter).
// -----------------------------------------------------------------------------
module ppu_bbus_master #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned TURN_CYCLES   = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [7:0]  req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic [7:0]  pa_o,
    output logic [7:0]  pd_out_o,
    output logic        pd_oe_o,
    input  logic [7:0]  pd_in_i,
    output logic        pard_n_o,
    output logic        pawr_n_o,
    output logic        lvl_pa_dir_o,
    output logic        lvl_pd_dir_o,
    output logic [15:0] stat_writes_o,
    output logic [15:0] stat_reads_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TURN   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] TURN_LOAD   = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

    state_e      state_q,     state_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        wr_q,        wr_d;
    logic [7:0]  data_q,      data_d;
    logic [7:0]  pa_q,        pa_d;
    logic [7:0]  pd_out_q,    pd_out_d;
    logic        pd_oe_q,     pd_oe_d;
    logic        pard_n_q,    pard_n_d;
    logic        pawr_n_q,    pawr_n_d;
    logic        pa_dir_q;
    logic        pd_dir_q,    pd_dir_d;
    logic        ready_q,     ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q,  rsp_data_d;
    logic        cnt_zero_s;
    logic        accept_s;

    assign cnt_zero_s = (cnt_q == 8'd0);
    // ready_q is only ever high in IDLE, so this is the handshake.
    assign accept_s   = req_valid_i && ready_q;

    // Next-state and next-output logic. Every output is computed one cycle
    // ahead from the state being entered so that the pins come straight off
    // flops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        data_d      = data_q;
        pa_d        = pa_q;
        pd_out_d    = pd_out_q;
        pd_oe_d     = pd_oe_q;
        pard_n_d    = pard_n_q;
        pawr_n_d    = pawr_n_q;
        pd_dir_d    = pd_dir_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    wr_d   = req_write_i;
                    data_d = req_data_i;
                    pa_d   = req_addr_i;
                    // The PD direction must equal the transfer direction.
                    if (req_write_i != pd_dir_q) begin
                        state_d  = ST_TURN;
                        cnt_d    = TURN_LOAD;
                        pd_dir_d = req_write_i;
                        pd_oe_d  = 1'b0;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                        if (req_write_i) begin
                            pd_out_d = req_data_i;
                            pd_oe_d  = 1'b1;
                        end else begin
                            pd_oe_d  = 1'b0;
                        end
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end

            ST_TURN: begin
                if (cnt_zero_s) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    if (wr_q) begin
                        pd_out_d = data_q;
                        pd_oe_d  = 1'b1;
                    end else begin
                        pd_oe_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_SETUP: begin
                if (cnt_zero_s) begin
                    state_d  = ST_STROBE;
                    cnt_d    = STROBE_LOAD;
                    pawr_n_d = ~wr_q;
                    pard_n_d = wr_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_STROBE: begin
                if (cnt_zero_s) begin
                    state_d  = ST_HOLD;
                    cnt_d    = HOLD_LOAD;
                    pawr_n_d = 1'b1;
                    pard_n_d = 1'b1;
                    // Read data is sampled at the edge that releases /PARD.
                    if (!wr_q) begin
                        rsp_data_d  = pd_in_i;
                        rsp_valid_d = 1'b1;
                    end else begin
                        rsp_data_d  = rsp_data_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_HOLD: begin
                if (cnt_zero_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    pd_oe_d = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = 8'd0;
                pd_oe_d  = 1'b0;
                pard_n_d = 1'b1;
                pawr_n_d = 1'b1;
            end
        endcase
    end

    // State, counter, latched request and all registered pins.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            wr_q        <= 1'b0;
            data_q      <= 8'd0;
            pa_q        <= 8'd0;
            pd_out_q    <= 8'd0;
            pd_oe_q     <= 1'b0;
            pard_n_q    <= 1'b1;
            pawr_n_q    <= 1'b1;
            pa_dir_q    <= 1'b0;
            pd_dir_q    <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            pa_q        <= pa_d;
            pd_out_q    <= pd_out_d;
            pd_oe_q     <= pd_oe_d;
            pard_n_q    <= pard_n_d;
            pawr_n_q    <= pawr_n_d;
            pa_dir_q    <= 1'b1;
            pd_dir_q    <= pd_dir_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign pa_o         = pa_q;
    assign pd_out_o     = pd_out_q;
    assign pd_oe_o      = pd_oe_q;
    assign pard_n_o     = pard_n_q;
    assign pawr_n_o     = pawr_n_q;
    assign lvl_pa_dir_o = pa_dir_q;
    assign lvl_pd_dir_o = pd_dir_q;

`ifdef PPU_BBUS_STATS_EN
    logic [15:0] stat_writes_q;
    logic [15:0] stat_reads_q;
    logic        last_hold_s;

    // Completion is the last HOLD cycle; an aborted transaction never gets here.
    assign last_hold_s = (state_q == ST_HOLD) && cnt_zero_s;

    // Completed-transaction counters, wrapping at 16 bits.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stat_writes_q <= 16'd0;
            stat_reads_q  <= 16'd0;
        end else if (last_hold_s) begin
            if (wr_q) begin
                stat_writes_q <= stat_writes_q + 16'd1;
            end else begin
                stat_reads_q  <= stat_reads_q + 16'd1;
            end
        end else begin
            stat_writes_q <= stat_writes_q;
            stat_reads_q  <= stat_reads_q;
        end
    end

    assign stat_writes_o = stat_writes_q;
    assign stat_reads_o  = stat_reads_q;
`else
    assign stat_writes_o = 16'd0;
    assign stat_reads_o  = 16'd0;
`endif

endmodule
